// File: rtl/seg_rdr.sv
// seg_rdr: seven-segment bus reader.
// Decodes a muxed 4-digit display bus back to nibbles.
module seg_rdr #(
  parameter int SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  segin,
  input  logic [3:0]  dig_sel,
  output logic [15:0] hex,
  output logic [3:0]  dp,
  output logic [3:0]  err,
  output logic        valid
);

  localparam logic [7:0] SAT  = 8'(SETTLE);
  localparam logic [7:0] LAST = 8'(SETTLE - 1);

  logic [11:0] smp;
  logic [11:0] r;
  logic [7:0]  cnt;
  logic [3:0]  seen;
  logic [3:0]  seen_nx;
  logic [1:0]  idx;
  logic        one;
  logic        same;
  logic        stb;
  logic [3:0]  nib;
  logic        legal;

  assign smp  = {dig_sel, segin};
  assign same = (smp == r);
  assign stb  = same && (cnt == LAST) && one;

  // only a single low select names a real digit
  always_comb begin
    one = 1'b1;
    idx = 2'd0;
    case (r[11:8])
      4'hE: idx = 2'd0;
      4'hD: idx = 2'd1;
      4'hB: idx = 2'd2;
      4'h7: idx = 2'd3;
      default: one = 1'b0;
    endcase
  end

  always_comb begin
    legal = 1'b1;
    nib   = 4'h0;
    case (r[6:0])
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h18: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h27: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
      default: legal = 1'b0;
    endcase
  end

  assign seen_nx = seen | (4'b0001 << idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r     <= '1;
      cnt   <= 8'd0;
      seen  <= 4'h0;
      hex   <= 16'h0000;
      dp    <= 4'h0;
      err   <= 4'h0;
      valid <= 1'b0;
    end else begin
      r     <= smp;
      valid <= 1'b0;
      if (!same)
        cnt <= 8'd0;
      else if (cnt != SAT)
        cnt <= cnt + 8'd1;
      if (stb) begin
        dp[idx] <= ~r[7];
        if (legal) begin
          hex[{idx, 2'b00} +: 4] <= nib;
          err[idx] <= 1'b0;
        end else begin
          err[idx] <= 1'b1;
        end
        if (seen_nx == 4'hF) begin
          seen  <= 4'h0;
          valid <= 1'b1;
        end else begin
          seen <= seen_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_rdr.sv
// tb_seg_rdr: directed bench for seg_rdr.
// SETTLE=4 and SETTLE=1 instances share one bus.
module tb_seg_rdr;

  logic        clk;
  logic        rst_n;
  logic [7:0]  segin;
  logic [3:0]  dig_sel;
  logic [15:0] hex4, hex1;
  logic [3:0]  dp4, dp1, err4, err1;
  logic        v4, v1;

  int total = 0;
  int bad   = 0;
  int vc4   = 0;
  int base;
  logic [15:0] h0;
  logic [3:0]  e0;
  logic [6:0]  gl [16];

  seg_rdr #(.SETTLE(4)) u4 (
    .clk(clk), .rst_n(rst_n), .segin(segin), .dig_sel(dig_sel),
    .hex(hex4), .dp(dp4), .err(err4), .valid(v4)
  );

  seg_rdr #(.SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .segin(segin), .dig_sel(dig_sel),
    .hex(hex1), .dp(dp1), .err(err1), .valid(v1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (v4) vc4 <= vc4 + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic [3:0] s, input logic [7:0] g,
                      input int n);
    dig_sel = s;
    segin   = g;
    repeat (n) @(negedge clk);
  endtask

  task automatic rst_pulse();
    dig_sel = 4'hF;
    segin   = 8'hFF;
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    gl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
           7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};
    rst_n   = 1'b0;
    dig_sel = 4'hF;
    segin   = 8'hFF;
    repeat (2) @(negedge clk);
    chk("rst_hex", hex4, 16'h0);
    chk("rst_dp", dp4, 4'h0);
    chk("rst_err", err4, 4'h0);
    chk("rst_valid", v4, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // normal scan
    base = vc4;
    hold(4'hE, 8'hF9, 6);
    hold(4'hD, 8'hA4, 6);
    hold(4'hB, 8'hB0, 6);
    chk("scan_novalid", vc4 - base, 0);
    hold(4'h7, 8'h99, 4);
    chk("scan_v_early", v4, 1'b0);
    @(negedge clk);
    chk("scan_v_pulse", v4, 1'b1);
    chk("scan_hex", hex4, 16'h4321);
    chk("scan_err", err4, 4'h0);
    chk("scan_dp", dp4, 4'h0);
    @(negedge clk);
    chk("scan_v_low", v4, 1'b0);
    chk("scan_vcount", vc4 - base, 1);

    // glitch rejection
    hold(4'hE, 8'h80, 6);
    chk("gl_pre8", hex4[3:0], 4'h8);
    hold(4'hE, 8'hF9, 2);
    hold(4'hE, 8'hC0, 2);
    chk("gl_no1", hex4[3:0], 4'h8);
    hold(4'hE, 8'hC0, 4);
    chk("gl_zero", hex4[3:0], 4'h0);

    // illegal glyph then F with dp
    hold(4'hB, 8'hFF, 6);
    chk("ill_err", err4[2], 1'b1);
    chk("ill_keep", hex4[11:8], 4'h3);
    hold(4'hB, 8'h0E, 6);
    chk("f_hex", hex4[11:8], 4'hF);
    chk("f_err", err4[2], 1'b0);
    chk("f_dp", dp4[2], 1'b1);

    // ghost selects
    h0 = hex4;
    e0 = err4;
    base = vc4;
    hold(4'hF, 8'hC0, 10);
    hold(4'hC, 8'hA4, 10);
    chk("gh_hex", hex4, h0);
    chk("gh_err", err4, e0);
    chk("gh_valid", vc4 - base, 0);

    // repeat digit
    rst_pulse();
    base = vc4;
    hold(4'hE, 8'hC0, 6);
    hold(4'hE, 8'hF9, 6);
    hold(4'hD, 8'hA4, 6);
    hold(4'hB, 8'hB0, 6);
    chk("rep_novalid", vc4 - base, 0);
    hold(4'h7, 8'h99, 6);
    chk("rep_valid", vc4 - base, 1);
    chk("rep_hex", hex4, 16'h4321);

    // mid-frame reset
    hold(4'hE, 8'hC0, 6);
    hold(4'hD, 8'hF9, 6);
    rst_n = 1'b0;
    #1;
    chk("mr_hex", hex4, 16'h0);
    chk("mr_err", err4, 4'h0);
    chk("mr_dp", dp4, 4'h0);
    chk("mr_valid", v4, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base = vc4;
    hold(4'h7, 8'h99, 6);
    hold(4'hB, 8'hB0, 6);
    hold(4'hD, 8'hA4, 6);
    chk("mr_novalid", vc4 - base, 0);
    hold(4'hE, 8'hF9, 6);
    chk("mr_valid2", vc4 - base, 1);
    chk("mr_hex2", hex4, 16'h4321);

    // SETTLE=1, 2-cycle slots, back-to-back frames
    rst_pulse();
    for (int f = 0; f < 3; f++) begin
      for (int d = 0; d < 4; d++) begin
        logic [3:0] s;
        logic [3:0] n;
        s = ~(4'b0001 << d);
        n = 4'(f * 4 + d + 5);
        dig_sel = s;
        segin   = {1'b1, gl[n]};
        @(negedge clk);
        chk("s1_v_a", v1, 1'b0);
        @(negedge clk);
        chk("s1_v_b", v1, (d == 3) ? 1'b1 : 1'b0);
        chk("s1_nib", hex1[4*d +: 4], n);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
